// File: rtl/app_flit_injector_pkg.sv
// Shared types and packet-layout constants for the application flit injector.
// Every NoC packet is a target flit, a size flit, then the payload words.
package app_flit_injector_pkg;

    localparam logic [1:0] HDR_IDX        = 2'd0;
    localparam logic [1:0] SIZE_IDX       = 2'd1;
    localparam logic [1:0] PAYLOAD_OFFSET = 2'd2;

    // Each sending state is encoded as the index of the flit slot it emits.
    typedef enum logic [1:0] {
        HEADER  = HDR_IDX,
        SIZE    = SIZE_IDX,
        PAYLOAD = PAYLOAD_OFFSET,
        IDLE    = 2'd3
    } inj_state_t;

    // Total number of flits on the wire for a packet with 'size' payload words.
    function automatic logic [16:0] pkt_flits(input logic [15:0] size);
        return {1'b0, size} + 17'(PAYLOAD_OFFSET);
    endfunction

endpackage

// File: rtl/app_flit_injector_if.sv
// Host-side descriptor/word handshakes and NoC-side credit port of the injector.
// The slave modport is the injector's view; the master modport is the host/NoC view.
interface app_flit_injector_if #(
    parameter int FLIT_SIZE = 32
);

    logic                 pkt_valid_i;
    logic                 pkt_ready_o;
    logic [15:0]          pkt_target_i;
    logic [15:0]          pkt_size_i;
    logic                 word_valid_i;
    logic                 word_ready_o;
    logic [FLIT_SIZE-1:0] word_data_i;
    logic                 eoa_i;
    logic                 eoa_o;
    logic                 tx_o;
    logic                 credit_i;
    logic [FLIT_SIZE-1:0] data_o;
    logic [31:0]          pkt_count_o;

    modport slave (
        input  pkt_valid_i,
        output pkt_ready_o,
        input  pkt_target_i,
        input  pkt_size_i,
        input  word_valid_i,
        output word_ready_o,
        input  word_data_i,
        input  eoa_i,
        output eoa_o,
        output tx_o,
        input  credit_i,
        output data_o,
        output pkt_count_o
    );

    modport master (
        output pkt_valid_i,
        input  pkt_ready_o,
        output pkt_target_i,
        output pkt_size_i,
        output word_valid_i,
        input  word_ready_o,
        output word_data_i,
        output eoa_i,
        input  eoa_o,
        input  tx_o,
        output credit_i,
        input  data_o,
        input  pkt_count_o
    );

endinterface

// File: rtl/inj_fifo.sv
// Synchronous payload FIFO; the head is read straight out of the register file at
// the registered read pointer, so a pushed word appears at the head one cycle later.
module inj_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/app_flit_injector.sv
// Credit-based NoC flit source: turns host packet descriptors plus a buffered
// payload word stream into target/size/payload flit sequences.
module app_flit_injector
    import app_flit_injector_pkg::*;
#(
    parameter int FLIT_SIZE  = 32,
    parameter int FIFO_DEPTH = 8
) (
    input logic                clk_i,
    input logic                rst_ni,
    app_flit_injector_if.slave bus
);

    inj_state_t           state_q;
    inj_state_t           state_d;
    logic [15:0]          target_q;
    logic [15:0]          remaining_q;
    logic [31:0]          pkt_count_q;
    logic                 eoa_q;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [FLIT_SIZE-1:0] fifo_head;

    logic                 tx;
    logic [FLIT_SIZE-1:0] data;
    logic                 pkt_ready;
    logic                 pkt_done;
    logic                 accept;

    assign accept = pkt_ready & bus.pkt_valid_i;

    inj_fifo #(
        .WIDTH (FLIT_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (bus.word_valid_i),
        .push_data (bus.word_data_i),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Outputs are decoded from state and registers only; credit_i affects just the
    // next state, so tx/data stay stable while the NoC withholds credit.
    always_comb begin
        state_d   = state_q;
        tx        = 1'b0;
        data      = '0;
        pkt_ready = 1'b0;
        fifo_pop  = 1'b0;
        pkt_done  = 1'b0;
        case (state_q)
            IDLE: begin
                pkt_ready = 1'b1;
                if (bus.pkt_valid_i) begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                tx   = 1'b1;
                data = FLIT_SIZE'(target_q);
                if (bus.credit_i) begin
                    state_d = SIZE;
                end
            end
            SIZE: begin
                tx   = 1'b1;
                data = FLIT_SIZE'(remaining_q);
                if (bus.credit_i) begin
                    if (remaining_q == 16'd0) begin
                        state_d  = IDLE;
                        pkt_done = 1'b1;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                tx   = ~fifo_empty;
                data = fifo_head;
                if (tx && bus.credit_i) begin
                    fifo_pop = 1'b1;
                    if (remaining_q == 16'd1) begin
                        state_d  = IDLE;
                        pkt_done = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // remaining_q holds the packet size until the size flit goes out, then counts
    // down the payload words still owed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            target_q    <= '0;
            remaining_q <= '0;
            pkt_count_q <= '0;
            eoa_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                target_q    <= bus.pkt_target_i;
                remaining_q <= bus.pkt_size_i;
            end else if (fifo_pop) begin
                remaining_q <= remaining_q - 16'd1;
            end
            if (pkt_done) begin
                pkt_count_q <= pkt_count_q + 32'd1;
            end
            eoa_q <= bus.eoa_i & (state_q == IDLE) & ~bus.pkt_valid_i & fifo_empty;
        end
    end

    assign bus.tx_o         = tx;
    assign bus.data_o       = data;
    assign bus.pkt_ready_o  = pkt_ready;
    assign bus.word_ready_o = ~fifo_full;
    assign bus.eoa_o        = eoa_q;
    assign bus.pkt_count_o  = pkt_count_q;

endmodule

// File: tb/tb_app_flit_injector.sv
// Directed bench for app_flit_injector: expected flits are queued as stimulus is
// issued and a negedge monitor checks every transferred flit against that queue.
module tb_app_flit_injector;
    import app_flit_injector_pkg::*;

    localparam int FLIT_SIZE  = 32;
    localparam int FIFO_DEPTH = 8;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    app_flit_injector_if #(.FLIT_SIZE(FLIT_SIZE)) bus();

    app_flit_injector #(
        .FLIT_SIZE  (FLIT_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic expectFlit(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    // Every transfer the NoC would see is popped against the expected-flit queue.
    task automatic monitor();
        logic [31:0] e;
        forever begin
            @(negedge clk_i);
            if (rst_ni && bus.tx_o && bus.credit_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_flit actual=0x%08h expected=none", bus.data_o);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("flit", bus.data_o, e);
                end
            end
        end
    endtask

    task automatic pushWord(input logic [31:0] w);
        bit accepted = 1'b0;
        bus.word_valid_i = 1'b1;
        bus.word_data_i  = w;
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge clk_i);
            accepted = bus.word_ready_o;
            nextCycle();
        end
        bus.word_valid_i = 1'b0;
        if (!accepted) begin
            total++;
            bad++;
            $display("[TB] FAIL word_push_timeout actual=no_accept required=accept word=0x%08h", w);
        end
    endtask

    task automatic sendDesc(input logic [15:0] target, input logic [15:0] size);
        bit accepted = 1'b0;
        bus.pkt_valid_i  = 1'b1;
        bus.pkt_target_i = target;
        bus.pkt_size_i   = size;
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge clk_i);
            accepted = bus.pkt_ready_o;
            nextCycle();
        end
        bus.pkt_valid_i = 1'b0;
        if (!accepted) begin
            total++;
            bad++;
            $display("[TB] FAIL desc_timeout actual=no_accept required=accept target=0x%04h", target);
        end
    endtask

    task automatic waitIdle(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_i);
            seen = bus.pkt_ready_o;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_timeout actual=busy required=idle", name);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_tx"},         32'(bus.tx_o),         32'd0);
        checkOutput({tag, "_data"},       bus.data_o,            32'd0);
        checkOutput({tag, "_pkt_ready"},  32'(bus.pkt_ready_o),  32'd1);
        checkOutput({tag, "_word_ready"}, 32'(bus.word_ready_o), 32'd1);
        checkOutput({tag, "_eoa"},        32'(bus.eoa_o),        32'd0);
        checkOutput({tag, "_pkt_count"},  bus.pkt_count_o,       32'd0);
    endtask

    task automatic applyStimulus(input int testId);
        case (testId)
            1: begin
                pushWord(32'hA);
                pushWord(32'hB);
                pushWord(32'hC);
                expectFlit(32'h0000_0102);
                expectFlit(32'h3);
                expectFlit(32'hA);
                expectFlit(32'hB);
                expectFlit(32'hC);
                sendDesc(16'h0102, 16'd3);
                @(negedge clk_i);
                checkOutput("single_hdr_tx", 32'(bus.tx_o), 32'd1);
                checkOutput("single_hdr_data", bus.data_o, 32'h0000_0102);
                for (int i = 1; i < int'(pkt_flits(16'd3)); i++) begin
                    @(negedge clk_i);
                    checkOutput("single_burst_tx", 32'(bus.tx_o), 32'd1);
                end
                @(negedge clk_i);
                checkOutput("single_ready_after", 32'(bus.pkt_ready_o), 32'd1);
                checkOutput("single_pkt_count", bus.pkt_count_o, 32'd1);
                nextCycle();
            end
            2: begin
                pushWord(32'hA);
                pushWord(32'hB);
                pushWord(32'hC);
                expectFlit(32'h0000_0102);
                expectFlit(32'h3);
                expectFlit(32'hA);
                expectFlit(32'hB);
                expectFlit(32'hC);
                sendDesc(16'h0102, 16'd3);
                repeat (3) @(posedge clk_i);
                #1;
                bus.credit_i = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk_i);
                    checkOutput("bp_hold_tx", 32'(bus.tx_o), 32'd1);
                    checkOutput("bp_hold_data", bus.data_o, 32'hB);
                end
                nextCycle();
                bus.credit_i = 1'b1;
                waitIdle("bp");
                checkOutput("bp_pkt_count", bus.pkt_count_o, 32'd2);
                nextCycle();
            end
            3: begin
                expectFlit(32'h0000_0305);
                expectFlit(32'h0);
                sendDesc(16'h0305, 16'd0);
                repeat (2) @(negedge clk_i);
                @(negedge clk_i);
                checkOutput("zero_ready", 32'(bus.pkt_ready_o), 32'd1);
                checkOutput("zero_tx_off", 32'(bus.tx_o), 32'd0);
                checkOutput("zero_pkt_count", bus.pkt_count_o, 32'd3);
                nextCycle();
            end
            4: begin
                for (int i = 0; i < 8; i++) begin
                    pushWord(32'h100 + 32'(i));
                end
                @(negedge clk_i);
                checkOutput("full_word_ready", 32'(bus.word_ready_o), 32'd0);
                nextCycle();
                expectFlit(32'h0000_0A0B);
                expectFlit(32'h8);
                for (int i = 0; i < 8; i++) begin
                    expectFlit(32'h100 + 32'(i));
                end
                fork
                    pushWord(32'h108);
                    sendDesc(16'h0A0B, 16'd8);
                join
                waitIdle("full");
                checkOutput("full_pkt_count", bus.pkt_count_o, 32'd4);
                nextCycle();
            end
            5: begin
                pushWord(32'h109);
                expectFlit(32'h0000_0708);
                expectFlit(32'h4);
                expectFlit(32'h108);
                expectFlit(32'h109);
                sendDesc(16'h0708, 16'd4);
                repeat (4) @(negedge clk_i);
                @(negedge clk_i);
                checkOutput("starve_tx", 32'(bus.tx_o), 32'd0);
                checkOutput("starve_busy", 32'(bus.pkt_ready_o), 32'd0);
                @(negedge clk_i);
                checkOutput("starve_tx_hold", 32'(bus.tx_o), 32'd0);
                #2;
                rst_ni = 1'b0;
                #1;
                checkResetValues("midreset");
                checkOutput("midreset_queue", 32'(exp_q.size()), 32'd0);
                nextCycle();
                rst_ni = 1'b1;
                nextCycle();
            end
            6: begin
                bus.eoa_i = 1'b1;
                @(negedge clk_i);
                checkOutput("eoa_not_yet", 32'(bus.eoa_o), 32'd0);
                nextCycle();
                bus.pkt_valid_i  = 1'b1;
                bus.pkt_target_i = 16'h0910;
                bus.pkt_size_i   = 16'd0;
                expectFlit(32'h0000_0910);
                expectFlit(32'h0);
                @(negedge clk_i);
                checkOutput("eoa_high", 32'(bus.eoa_o), 32'd1);
                nextCycle();
                bus.pkt_valid_i = 1'b0;
                @(negedge clk_i);
                checkOutput("eoa_drop", 32'(bus.eoa_o), 32'd0);
                waitIdle("eoa");
                checkOutput("eoa_pkt_count", bus.pkt_count_o, 32'd1);
                repeat (2) @(negedge clk_i);
                checkOutput("eoa_return", 32'(bus.eoa_o), 32'd1);
                nextCycle();
                bus.eoa_i = 1'b0;
            end
            default: begin
            end
        endcase
    endtask

    initial begin
        bus.pkt_valid_i  = 1'b0;
        bus.pkt_target_i = '0;
        bus.pkt_size_i   = '0;
        bus.word_valid_i = 1'b0;
        bus.word_data_i  = '0;
        bus.eoa_i        = 1'b0;
        bus.credit_i     = 1'b1;
        rst_ni           = 1'b0;

        fork
            monitor();
            begin
                #200000;
                $display("[TB] FAIL watchdog actual=running required=finished");
                bad++;
                $display("test done: total=%0d bad=%0d", total, bad);
                $fatal(1, "[TB] watchdog expired");
            end
        join_none

        #12;
        checkResetValues("reset");
        nextCycle();
        rst_ni = 1'b1;
        nextCycle();

        for (int t = 1; t <= 6; t++) begin
            applyStimulus(t);
        end

        repeat (3) nextCycle();
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/app_flit_injector.md
# app_flit_injector

Synthesizable credit-based flit source that turns host packet descriptors and a payload word stream into NoC packets for the many-core's application injection port (`app_src_rx_i` / `app_src_credit_o` / `app_src_data_i` / `app_src_eoa_i`). It replaces the file-driven application injector wherever a real host or bridge supplies the traffic. Payload words are decoupled from the NoC handshake by an internal FIFO.

## Interface
- `FLIT_SIZE`, 32: flit and payload word width. Must be ≥ 16.
- `FIFO_DEPTH`, 8: payload FIFO entries. Must be a power of two, ≥ 2.
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `pkt_valid_i`  in  1  descriptor valid.
- `pkt_ready_o`  out  1  descriptor accepted when `pkt_valid_i & pkt_ready_o`.
- `pkt_target_i`  in  16  destination PE address {x[15:8], y[7:0]}.
- `pkt_size_i`  in  16  payload flit count, 0..65535.
- `word_valid_i`  in  1  payload word valid.
- `word_ready_o`  out  1  payload word accepted when both are high.
- `word_data_i`  in  FLIT_SIZE  payload word.
- `eoa_i`  in  1  host level meaning "no further packets".
- `eoa_o`  out  1  end-of-applications to the many-core.
- `tx_o`  out  1  flit valid toward the NoC.
- `credit_i`  in  1  NoC can accept a flit this cycle.
- `data_o`  out  FLIT_SIZE  flit.
- `pkt_count_o`  out  32  packets fully sent since reset, wraps at 2^32.

## Operation
- Packet format: flit 0 is the target zero-extended to FLIT_SIZE. Flit 1 is the size zero-extended. Flits 2..size+1 are the payload, in FIFO order.
- A flit transfers in any cycle with `tx_o & credit_i`. While `tx_o=1` and `credit_i=0`, `data_o` holds. `tx_o` never drops before a transfer, except by reset.
- FSM states: IDLE, HEADER, SIZE, PAYLOAD.
  - IDLE: `pkt_ready_o=1`. On accept, latch target and size into `remaining`, then go to HEADER.
  - HEADER: `tx_o=1`, `data_o=target`. On transfer, go to SIZE.
  - SIZE: `tx_o=1`, `data_o=size`. On transfer, go to PAYLOAD if size≠0. If size=0, go to IDLE and increment `pkt_count_o`.
  - PAYLOAD: `tx_o = !fifo_empty`, `data_o` = FIFO head. On transfer, pop and decrement `remaining`. When `remaining==1` at the transfer, go to IDLE and increment `pkt_count_o`.
- `pkt_ready_o` is high only in IDLE. A new descriptor is accepted no earlier than the cycle after the last flit transfers.
- FIFO:
  - `word_ready_o = !full`. There is no same-cycle bypass, so a word is visible on `data_o` no earlier than the cycle after its push.
  - Push and pop in the same cycle are legal when the FIFO is neither empty nor full; occupancy is then unchanged.
  - The host may push words before the descriptor that owns them. The block never inspects word ownership; the host must supply exactly `size` words per packet.
- `eoa_o` is registered: next value = `eoa_i & (state==IDLE) & !pkt_valid_i & fifo_empty`. It is not sticky.
- Width rules: `remaining` is 16 bits. `pkt_count_o` is a 32-bit wrapping counter.

## Timing
- Reset values: `tx_o=0`, `data_o=0`, `pkt_ready_o=1`, `word_ready_o=1`, `eoa_o=0`, `pkt_count_o=0`, state=IDLE, FIFO empty.
- `tx_o` and `data_o` depend only on registers; there is no combinational path from `credit_i`.
- Descriptor accept at cycle T puts the header on `data_o` with `tx_o=1` at T+1.
- With `credit_i` held high and the FIFO pre-filled, a packet of size N occupies N+2 consecutive cycles. `pkt_ready_o` rises the cycle after the last transfer.
- Starvation: FIFO empty in PAYLOAD gives `tx_o=0`. The FSM waits there indefinitely, and a word pushed at T is sent at T+1 at the earliest.
- Reset mid-packet: asynchronous clear of all state and the FIFO. `tx_o` drops immediately and the partial packet is abandoned; the NoC is reset together with this block.

## Structure
- The shared package holds the `inj_state_t` enum (IDLE, HEADER, SIZE, PAYLOAD) and the packet-layout constants: header index 0, size index 1, payload offset 2.
- One sub-module, `inj_fifo`: a synchronous FIFO parameterized on width and depth, with push/pop/full/empty and a registered head. It is instantiated once.

## Test plan
- Single packet: target 0x0102, size 3, words 0xA, 0xB, 0xC pre-pushed, `credit_i=1` → flits 0x00000102, 0x3, 0xA, 0xB, 0xC on five consecutive cycles from T+1; `pkt_count_o=1`.
- Backpressure: same packet with `credit_i` low for 4 cycles during flit 0xB → `data_o` holds 0xB with `tx_o=1` for 4 cycles; no loss or duplication.
- Zero size: target 0x0305, size 0 → exactly two flits (0x305, 0x0), then IDLE; `pkt_count_o` increments.
- FIFO full: push 9 words with no descriptor → `word_ready_o` falls after the 8th word; then descriptor size 8 → all 8 words drain in order and the 9th is accepted once space frees.
- Starvation plus reset: size 4 with 2 words available → `tx_o` low after the 2nd payload flit. Assert `rst_ni` low mid-wait → all outputs reach their reset values asynchronously.
- EOA: `eoa_i=1` while idle and the FIFO is empty → `eoa_o=1` next cycle. Raise `pkt_valid_i` → `eoa_o=0` the following cycle.
